// File: rtl/spi_window_receiver.sv
// Oversampled SPI column ingest building a sliding KSIZE x KSIZE pixel window with valid/ready output.
// Define SPI_CS_ABORT_EN to drop a partial message when chip select deasserts mid-message.
module spi_window_receiver #(
  parameter int PIX_BITS    = 4,
  parameter int KSIZE       = 3,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               mainClk,
  input  logic                               reset,
  input  logic                               spiClk,
  input  logic                               ncs,
  input  logic                               sdi,
  input  logic                               windowReady,
  output logic [KSIZE*KSIZE*PIX_BITS-1:0]    pixelWindow,
  output logic                               windowValid,
  output logic [$clog2(IMG_WIDTH)-1:0]       winX,
  output logic [$clog2(IMG_HEIGHT)-1:0]      winY,
  output logic                               frameDone,
  output logic                               overflow
);

  localparam int MSG_BITS = KSIZE * PIX_BITS;
  localparam int WIN_BITS = KSIZE * MSG_BITS;
  localparam int XW       = $clog2(IMG_WIDTH);
  localparam int YW       = $clog2(IMG_HEIGHT);
  localparam int CW       = $clog2(MSG_BITS);
  localparam int FW       = $clog2(KSIZE + 1);

  localparam logic [XW-1:0] X_LAST    = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(MSG_BITS - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(KSIZE);

  typedef enum logic {IDLE, VALID} state_t;

  logic [SYNC_STAGES-1:0] sclk_sr, ncs_sr, sdi_sr;
  logic                   sclk_prev;
  logic                   sclk_s, ncs_s, sdi_s;
  logic                   sample;
  logic [MSG_BITS-1:0]    shreg, msg_next;
  logic [CW-1:0]          bit_cnt;
  logic                   col_done;
  logic [MSG_BITS-1:0]    new_col;
  logic [WIN_BITS-1:0]    win_store, window_next;
  logic [FW-1:0]          fill, fill_next;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic                   qualify;
  state_t                 state, state_next;
  logic                   load, set_ovf;

  always_ff @(posedge mainClk) begin
    if (reset) begin
      sclk_sr   <= '0;
      ncs_sr    <= '1;
      sdi_sr    <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], spiClk};
      ncs_sr    <= {ncs_sr[SYNC_STAGES-2:0], ncs};
      sdi_sr    <= {sdi_sr[SYNC_STAGES-2:0], sdi};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s   = sclk_sr[SYNC_STAGES-1];
  assign ncs_s    = ncs_sr[SYNC_STAGES-1];
  assign sdi_s    = sdi_sr[SYNC_STAGES-1];
  assign sample   = sclk_s & ~sclk_prev & ~ncs_s;
  assign msg_next = {shreg[MSG_BITS-2:0], sdi_s};
  assign col_done = sample && (bit_cnt == CNT_LAST);

`ifdef SPI_CS_ABORT_EN
  logic ncs_prev;
  logic ncs_rise;

  always_ff @(posedge mainClk) begin
    if (reset) ncs_prev <= 1'b1;
    else       ncs_prev <= ncs_s;
  end

  assign ncs_rise = ncs_s & ~ncs_prev;

  // Sampling needs ncs low, so an abort can never coincide with a shift.
  always_ff @(posedge mainClk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (sample) begin
      shreg   <= msg_next;
      bit_cnt <= col_done ? '0 : bit_cnt + CW'(1);
    end else if (ncs_rise && (bit_cnt != '0)) begin
      bit_cnt <= '0;
    end
  end
`else
  always_ff @(posedge mainClk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (sample) begin
      shreg   <= msg_next;
      bit_cnt <= col_done ? '0 : bit_cnt + CW'(1);
    end
  end
`endif

  // First-received pixel (message MSBs) becomes row 0.
  always_comb begin
    new_col = '0;
    for (int r = 0; r < KSIZE; r++) begin
      new_col[r*PIX_BITS +: PIX_BITS] = msg_next[MSG_BITS-1-r*PIX_BITS -: PIX_BITS];
    end
  end

  assign window_next = {new_col, win_store[WIN_BITS-1:MSG_BITS]};

  always_comb begin
    fill_next = fill;
    if (x == '0)               fill_next = FW'(1);
    else if (fill != FILL_FULL) fill_next = fill + FW'(1);
  end

  assign qualify = col_done && (fill_next == FILL_FULL);

  always_ff @(posedge mainClk) begin
    if (reset) begin
      win_store <= '0;
      fill      <= '0;
      x         <= '0;
      y         <= '0;
      frameDone <= 1'b0;
    end else begin
      frameDone <= col_done && (x == X_LAST) && (y == Y_LAST);
      if (col_done) begin
        win_store <= window_next;
        fill      <= fill_next;
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge mainClk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    set_ovf    = 1'b0;
    case (state)
      IDLE: begin
        if (qualify) begin
          load       = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (qualify) begin
          load    = 1'b1;
          set_ovf = ~windowReady;
        end else if (windowReady) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge mainClk) begin
    if (reset) begin
      pixelWindow <= '0;
      winX        <= '0;
      winY        <= '0;
      overflow    <= 1'b0;
    end else begin
      if (load) begin
        pixelWindow <= window_next;
        winX        <= x;
        winY        <= y;
      end
      if (set_ovf) overflow <= 1'b1;
    end
  end

  assign windowValid = (state == VALID);

endmodule

// File: tb/tb_spi_window_receiver.sv
// Directed bench for spi_window_receiver; frame geometry reduced to 20x4 to keep full-frame runs short.
module tb_spi_window_receiver;

  localparam int W = 20;
  localparam int H = 4;

  logic        mainClk = 1'b0;
  logic        reset, spiClk, ncs, sdi, windowReady;
  logic [35:0] pixelWindow;
  logic        windowValid;
  logic [4:0]  winX;
  logic [1:0]  winY;
  logic        frameDone, overflow;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int fd_cnt = 0;
  logic [35:0] hs_win = '0;
  logic [4:0]  hs_x = '0;
  logic [1:0]  hs_y = '0;

  always #5 mainClk = ~mainClk;

  spi_window_receiver #(
    .PIX_BITS(4), .KSIZE(3), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SYNC_STAGES(2)
  ) dut (
    .mainClk(mainClk), .reset(reset), .spiClk(spiClk), .ncs(ncs), .sdi(sdi),
    .windowReady(windowReady), .pixelWindow(pixelWindow), .windowValid(windowValid),
    .winX(winX), .winY(winY), .frameDone(frameDone), .overflow(overflow)
  );

  // Inputs only change 2ns after a rising edge, so the falling edge sees settled handshakes.
  always @(negedge mainClk) begin
    if (!reset) begin
      if (windowValid && windowReady) begin
        hs_cnt = hs_cnt + 1;
        hs_win = pixelWindow;
        hs_x   = winX;
        hs_y   = winY;
      end
      if (frameDone) fd_cnt = fd_cnt + 1;
    end
  end

  function automatic logic [11:0] col_of(input logic [11:0] m);
    return {m[3:0], m[7:4], m[11:8]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge mainClk);
    #2;
  endtask

  task automatic spi_bits(input logic [15:0] v, input int n);
    ncs = 1'b0;
    tick(2);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      tick(4);
      spiClk = 1'b1;
      tick(4);
      spiClk = 1'b0;
    end
  endtask

  task automatic send_col(input logic [11:0] m);
    spi_bits({4'h0, m}, 12);
    ncs = 1'b1;
    tick(4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    spiClk = 1'b0;
    ncs = 1'b1;
    sdi = 1'b0;
    windowReady = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (windowValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", windowValid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b expected 0", overflow); end
    checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL reset_framedone got %b expected 0", frameDone); end
    checks++; if (pixelWindow !== 36'h0) begin errors++; $display("FAIL reset_window got %h expected 0", pixelWindow); end
    checks++; if (winX !== 5'd0) begin errors++; $display("FAIL reset_winx got %0d expected 0", winX); end
    checks++; if (winY !== 2'd0) begin errors++; $display("FAIL reset_winy got %0d expected 0", winY); end
  endtask

  task automatic test_first_window();
    int base;
    do_reset();
    base = hs_cnt;
    send_col(12'hABC);
    send_col(12'h123);
    checks++; if (hs_cnt - base !== 0) begin errors++; $display("FAIL s1_early_windows got %0d expected 0", hs_cnt - base); end
    send_col(12'h456);
    checks++; if (hs_cnt - base !== 1) begin errors++; $display("FAIL s1_windows got %0d expected 1", hs_cnt - base); end
    checks++; if (hs_win !== 36'h654321CBA) begin errors++; $display("FAIL s1_window got %h expected 654321cba", hs_win); end
    checks++; if (hs_x !== 5'd2) begin errors++; $display("FAIL s1_winx got %0d expected 2", hs_x); end
    checks++; if (hs_y !== 2'd0) begin errors++; $display("FAIL s1_winy got %0d expected 0", hs_y); end
  endtask

  task automatic test_partial_fill();
    int base;
    do_reset();
    base = hs_cnt;
    send_col(12'hABC);
    send_col(12'h123);
    tick(10);
    checks++; if (windowValid !== 1'b0 || hs_cnt != base) begin errors++; $display("FAIL s2_no_window got valid=%b n=%0d expected valid=0 n=0", windowValid, hs_cnt - base); end
    send_col(12'h456);
    send_col(12'h789);
    checks++; if (hs_cnt - base !== 2) begin errors++; $display("FAIL s2_windows got %0d expected 2", hs_cnt - base); end
    checks++; if (hs_win !== 36'h987654321) begin errors++; $display("FAIL s2_window got %h expected 987654321", hs_win); end
    checks++; if (hs_x !== 5'd3) begin errors++; $display("FAIL s2_winx got %0d expected 3", hs_x); end
  endtask

  task automatic test_row_wrap();
    int base;
    do_reset();
    base = hs_cnt;
    for (int i = 0; i < W; i++) send_col(12'(i));
    checks++; if (hs_cnt - base !== W - 2) begin errors++; $display("FAIL s3_row0_windows got %0d expected %0d", hs_cnt - base, W - 2); end
    checks++; if (hs_win !== {col_of(12'(W-1)), col_of(12'(W-2)), col_of(12'(W-3))}) begin errors++; $display("FAIL s3_row0_window got %h", hs_win); end
    checks++; if (hs_x !== 5'(W-1)) begin errors++; $display("FAIL s3_row0_winx got %0d expected %0d", hs_x, W - 1); end
    checks++; if (hs_y !== 2'd0) begin errors++; $display("FAIL s3_row0_winy got %0d expected 0", hs_y); end
    send_col(12'(W));
    send_col(12'(W+1));
    checks++; if (hs_cnt - base !== W - 2) begin errors++; $display("FAIL s3_newrow_nowin got %0d expected %0d", hs_cnt - base, W - 2); end
    send_col(12'(W+2));
    checks++; if (hs_cnt - base !== W - 1) begin errors++; $display("FAIL s3_row1_windows got %0d expected %0d", hs_cnt - base, W - 1); end
    checks++; if (hs_win !== {col_of(12'(W+2)), col_of(12'(W+1)), col_of(12'(W))}) begin errors++; $display("FAIL s3_row1_window got %h", hs_win); end
    checks++; if (hs_x !== 5'd2) begin errors++; $display("FAIL s3_row1_winx got %0d expected 2", hs_x); end
    checks++; if (hs_y !== 2'd1) begin errors++; $display("FAIL s3_row1_winy got %0d expected 1", hs_y); end
  endtask

  task automatic test_backpressure();
    int base;
    do_reset();
    windowReady = 1'b0;
    base = hs_cnt;
    send_col(12'hABC);
    send_col(12'h123);
    send_col(12'h456);
    checks++; if (windowValid !== 1'b1) begin errors++; $display("FAIL s4_valid got %b expected 1", windowValid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL s4_no_overflow got %b expected 0", overflow); end
    checks++; if (winX !== 5'd2) begin errors++; $display("FAIL s4_held_winx got %0d expected 2", winX); end
    send_col(12'h789);
    tick(6);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL s4_overflow got %b expected 1", overflow); end
    checks++; if (windowValid !== 1'b1) begin errors++; $display("FAIL s4_still_valid got %b expected 1", windowValid); end
    checks++; if (pixelWindow !== 36'h987654321) begin errors++; $display("FAIL s4_window got %h expected 987654321", pixelWindow); end
    checks++; if (winX !== 5'd3) begin errors++; $display("FAIL s4_winx got %0d expected 3", winX); end
    checks++; if (hs_cnt != base) begin errors++; $display("FAIL s4_no_handshake got %0d expected 0", hs_cnt - base); end
    windowReady = 1'b1;
    tick(1);
    checks++; if (windowValid !== 1'b0) begin errors++; $display("FAIL s4_valid_drop got %b expected 0", windowValid); end
    checks++; if (hs_cnt - base !== 1) begin errors++; $display("FAIL s4_handshakes got %0d expected 1", hs_cnt - base); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL s4_overflow_sticky got %b expected 1", overflow); end
  endtask

  task automatic test_cs_gap();
    int base;
    logic [35:0] exp_win;
    do_reset();
    base = hs_cnt;
    send_col(12'hABC);
    send_col(12'h123);
    spi_bits(16'h0016, 5);
    ncs = 1'b1;
    tick(6);
    spi_bits(16'h0DEF, 12);
    ncs = 1'b1;
    tick(6);
`ifdef SPI_CS_ABORT_EN
    exp_win = {col_of(12'hDEF), col_of(12'h123), col_of(12'hABC)};
`else
    exp_win = {col_of(12'hB6F), col_of(12'h123), col_of(12'hABC)};
`endif
    checks++; if (hs_cnt - base !== 1) begin errors++; $display("FAIL s5_windows got %0d expected 1", hs_cnt - base); end
    checks++; if (hs_win !== exp_win) begin errors++; $display("FAIL s5_window got %h expected %h", hs_win, exp_win); end
  endtask

  task automatic test_reset_mid_msg_and_frame();
    int base, fbase;
    do_reset();
    spi_bits(16'h0055, 7);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    ncs = 1'b1;
    spiClk = 1'b0;
    tick(3);
    base = hs_cnt;
    fbase = fd_cnt;
    send_col(12'hABC);
    send_col(12'h123);
    send_col(12'h456);
    checks++; if (hs_cnt - base !== 1) begin errors++; $display("FAIL s6_windows got %0d expected 1", hs_cnt - base); end
    checks++; if (hs_win !== 36'h654321CBA || hs_x !== 5'd2 || hs_y !== 2'd0) begin errors++; $display("FAIL s6_window got %h x=%0d y=%0d expected 654321cba x=2 y=0", hs_win, hs_x, hs_y); end
    for (int i = 3; i < W*H-1; i++) send_col(12'(i));
    checks++; if (fd_cnt != fbase) begin errors++; $display("FAIL s6_early_framedone got %0d expected 0", fd_cnt - fbase); end
    send_col(12'hFFF);
    checks++; if (fd_cnt - fbase !== 1) begin errors++; $display("FAIL s6_framedone got %0d expected 1", fd_cnt - fbase); end
    send_col(12'h111);
    send_col(12'h222);
    send_col(12'h333);
    checks++; if (hs_x !== 5'd2 || hs_y !== 2'd0) begin errors++; $display("FAIL s6_wrap got x=%0d y=%0d expected x=2 y=0", hs_x, hs_y); end
    checks++; if (hs_win !== 36'h333222111) begin errors++; $display("FAIL s6_wrap_window got %h expected 333222111", hs_win); end
  endtask

  initial begin
    reset = 1'b1;
    spiClk = 1'b0;
    ncs = 1'b1;
    sdi = 1'b0;
    windowReady = 1'b1;
    test_reset();
    test_first_window();
    test_partial_fill();
    test_row_wrap();
    test_backpressure();
    test_cs_gap();
    test_reset_mid_msg_and_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
